fft_peak_detect: RTL
====================

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter NFFT_LOG2, default 10, log2 of FFT frame length (frame = 2^NFFT_LOG2 bins).
REQ-002 SHALL have parameter PIPE_LAT, default 2, fixed datapath latency in enabled cycles; only the value 2 is legal.
REQ-003 aclk  in  1  the single clock; all logic on rising edge.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 s_axis_data_tdata  in  32  FFT output sample; [15:0] real, [31:16] imag, both signed two's complement.
REQ-006 s_axis_data_tvalid / s_axis_data_tlast  in  1 each  input beat valid / last bin of frame.
REQ-007 s_axis_data_tready  out  1  input accept.
REQ-008 m_axis_power_tdata  out  32  unsigned power re^2+im^2 for each bin.
REQ-009 m_axis_power_tuser  out  NFFT_LOG2  bin index of the power beat.
REQ-010 m_axis_power_tvalid / m_axis_power_tlast  out  1 each  power beat valid / last bin.
REQ-011 m_axis_power_tready  in  1  downstream accept.
REQ-012 peak_bin  out  NFFT_LOG2; peak_power  out  32; peak_valid  out  1  per-frame peak report.
REQ-013 frame_err  out  1  frame length mismatch flag.

Function
REQ-014 Power SHALL be computed at full precision: signed 16x16 squares summed into 32 bits unsigned; (-32768)^2 x2 = 0x8000_0000 SHALL not overflow.
REQ-015 Datapath SHALL be a 2-stage pipeline (square, sum) with per-stage valid bits; pipeline advances when en = !m_axis_power_tvalid || m_axis_power_tready.
REQ-016 s_axis_data_tready SHALL equal en; input beat transfers on tvalid && tready.
REQ-017 An accepted beat SHALL appear on m_axis_power after exactly 2 enabled cycles; tdata/tuser/tlast SHALL hold stable while tvalid && !tready.
REQ-018 Bin index SHALL come from an internal counter, 0 on reset, incremented per input transfer, reset to 0 after a tlast transfer; wraps modulo 2^NFFT_LOG2.
REQ-019 Peak search SHALL use output-side transfers only; state machine IDLE -> SEARCH on first transfer of a frame, SEARCH -> REPORT on tlast transfer, REPORT -> IDLE after one cycle (REPORT -> SEARCH if a transfer occurs that cycle).
REQ-020 First bin of a frame SHALL load the running max unconditionally; later bins replace it only if strictly greater (ties keep lowest bin).
REQ-021 The tlast bin SHALL participate in the comparison before the report.
REQ-022 peak_valid SHALL pulse exactly one cycle in REPORT; peak_bin/peak_power SHALL hold until next report.
REQ-023 frame_err SHALL set at a tlast transfer when counter != 2^NFFT_LOG2-1, or when counter wraps without tlast; cleared at first beat of next frame.
REQ-024 A frame missing tlast SHALL keep searching across the wrap (no report) until tlast arrives.

Reset
REQ-025 On areset: all pipeline valids, m_axis_power_tvalid, peak_valid, frame_err = 0; peak_bin, peak_power, counter = 0; FSM = IDLE; s_axis_data_tready = 1 the cycle after.
REQ-026 Reset mid-frame SHALL discard in-flight beats and partial peak without a report.

Configuration
REQ-027 Macro FFT_PEAK_SKIP_DC_EN: when defined, bin 0 SHALL be excluded from peak search (bin 1 loads the max); power stream unchanged.
REQ-028 When undefined, bin 0 SHALL participate normally.

Structure
REQ-029 Shared package fft_pkg SHALL hold the FSM state typedef (IDLE, SEARCH, REPORT), sample field widths (16), and power width (32).
REQ-030 Sub-module fft_power_calc (2-stage square/sum with enable) SHALL be instantiated once.

Verification
REQ-031 Reset then single beat re=3, im=-4, tlast=1, ready=1 -> power 25 two cycles later, tuser=0, tlast=1, peak_valid pulse with peak_bin=0, peak_power=25.
REQ-032 1024-bin frame, bin 37 = (1000,0), others 0 -> peak_bin=37, peak_power=1_000_000, frame_err=0.
REQ-033 Bins 5 and 9 both (100,100), others 0 -> peak_bin=5, peak_power=20000.
REQ-034 m_axis_power_tready low 10 cycles mid-frame -> s_axis_data_tready low, no beat lost/duplicated, outputs stable.
REQ-035 tlast at bin 511 -> frame_err=1, peak reported; next full frame clears frame_err.
REQ-036 Bin 0 = (32767,0), bin 3 = (10,0), FFT_PEAK_SKIP_DC_EN defined -> peak_bin=3, peak_power=100; undefined -> peak_bin=0, peak_power=1073676289.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and widths for the FFT peak detector.
//   state_t  : peak-search FSM states (IDLE, SEARCH, REPORT)
//   SAMPLE_W : width of each signed real/imag component
//   POWER_W  : width of the unsigned power word
package fft_pkg;
    localparam int SAMPLE_W = 16;
    localparam int POWER_W  = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        REPORT = 2'd2
    } state_t;
endpackage

// File: rtl/fft_peak_detect_if.sv
// AXI-Stream style bus used for both the sample input and the power output.
//   tdata/tuser/tvalid/tlast : driven by the master
//   tready                   : driven by the slave
// DW = data width, UW = tuser width.
interface fft_peak_detect_if
    import fft_pkg::*;
#(
    parameter int DW = POWER_W,
    parameter int UW = 1
) ();
    logic [DW-1:0] tdata;
    logic [UW-1:0] tuser;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/fft_power_calc.sv
// Two-stage power pipeline: stage 1 squares re and im, stage 2 sums them.
// The whole pipe advances only when i_en is high, so a stalled output
// freezes every stage and holds the output word stable.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_en              : pipeline advance
//   i_vld/i_re/i_im   : input beat and signed components
//   i_bin/i_last      : side-band carried alongside the beat
//   o_vld/o_power/o_bin/o_last : pipelined result
module fft_power_calc
    import fft_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic                       i_vld,
    input  logic signed [SAMPLE_W-1:0] i_re,
    input  logic signed [SAMPLE_W-1:0] i_im,
    input  logic [BIN_W-1:0]           i_bin,
    input  logic                       i_last,
    output logic                       o_vld,
    output logic [POWER_W-1:0]         o_power,
    output logic [BIN_W-1:0]           o_bin,
    output logic                       o_last
);
    logic [STAGES:0]           vld_pipe;
    logic signed [POWER_W-1:0] w_re2, w_im2;
    logic [POWER_W-1:0]        r_re2, r_im2, r_pow;
    logic [BIN_W-1:0]          r_bin1, r_bin2;
    logic                      r_last1, r_last2;

    // Each square is at most 2^30, so the sum peaks at 2^31 and fits unsigned.
    assign w_re2 = i_re * i_re;
    assign w_im2 = i_im * i_im;

    assign vld_pipe[0] = i_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            r_re2   <= '0;
            r_im2   <= '0;
            r_pow   <= '0;
            r_bin1  <= '0;
            r_bin2  <= '0;
            r_last1 <= 1'b0;
            r_last2 <= 1'b0;
        end else if (i_en) begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            r_re2   <= w_re2;
            r_im2   <= w_im2;
            r_bin1  <= i_bin;
            r_last1 <= i_last;
            r_pow   <= r_re2 + r_im2;
            r_bin2  <= r_bin1;
            r_last2 <= r_last1;
        end
    end

    assign o_vld   = vld_pipe[STAGES];
    assign o_power = r_pow;
    assign o_bin   = r_bin2;
    assign o_last  = r_last2;
endmodule

// File: rtl/fft_peak_detect.sv
// FFT bin power calculator with per-frame peak search.
// Optional feature macro: FFT_PEAK_SKIP_DC_EN (exclude bin 0 from the search).
// Ports:
//   aclk, areset   : clock, synchronous active-high reset
//   s_axis_data    : input samples, tdata = {imag[15:0], real[15:0]}
//   m_axis_power   : output power stream, tuser = bin index
//   peak_bin/peak_power/peak_valid : per-frame peak report
//   frame_err      : frame length mismatch flag
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int NFFT_LOG2 = 10,
    parameter int PIPE_LAT  = 2
) (
    input  logic                  aclk,
    input  logic                  areset,
    fft_peak_detect_if.slave      s_axis_data,
    fft_peak_detect_if.master     m_axis_power,
    output logic [NFFT_LOG2-1:0]  peak_bin,
    output logic [POWER_W-1:0]    peak_power,
    output logic                  peak_valid,
    output logic                  frame_err
);
    localparam logic [NFFT_LOG2-1:0] LAST_BIN = '1;
`ifdef FFT_PEAK_SKIP_DC_EN
    localparam logic SKIP_DC = 1'b1;
`else
    localparam logic SKIP_DC = 1'b0;
`endif

    logic                 w_en, w_in_xfer, w_out_xfer;
    logic [NFFT_LOG2-1:0] r_cnt;
    logic                 w_pv, w_plast;
    logic [POWER_W-1:0]   w_pw;
    logic [NFFT_LOG2-1:0] w_pbin;
    logic                 w_unused_tuser;

    assign w_unused_tuser = ^s_axis_data.tuser;

    assign w_en               = !w_pv || m_axis_power.tready;
    assign s_axis_data.tready = w_en;
    assign w_in_xfer          = s_axis_data.tvalid && w_en;

    always_ff @(posedge aclk) begin
        if (areset)
            r_cnt <= '0;
        else if (w_in_xfer)
            r_cnt <= s_axis_data.tlast ? '0 : r_cnt + NFFT_LOG2'(1);
    end

    fft_power_calc #(.BIN_W(NFFT_LOG2), .STAGES(PIPE_LAT)) u_power_calc (
        .clk     (aclk),
        .rst     (areset),
        .i_en    (w_en),
        .i_vld   (s_axis_data.tvalid),
        .i_re    (s_axis_data.tdata[SAMPLE_W-1:0]),
        .i_im    (s_axis_data.tdata[2*SAMPLE_W-1:SAMPLE_W]),
        .i_bin   (r_cnt),
        .i_last  (s_axis_data.tlast),
        .o_vld   (w_pv),
        .o_power (w_pw),
        .o_bin   (w_pbin),
        .o_last  (w_plast)
    );

    assign m_axis_power.tvalid = w_pv;
    assign m_axis_power.tdata  = w_pw;
    assign m_axis_power.tuser  = w_pbin;
    assign m_axis_power.tlast  = w_plast;
    assign w_out_xfer          = w_pv && m_axis_power.tready;

    // Peak search runs on output-side transfers only.
    state_t               r_state, w_state_nxt;
    logic [POWER_W-1:0]   r_max, w_max_nxt, r_peak_power;
    logic [NFFT_LOG2-1:0] r_max_bin, w_bin_nxt, r_peak_bin;
    logic                 r_have, r_err;
    logic                 w_first, w_have, w_use, w_load, w_err_hit;

    // Outside SEARCH the running max is stale, so the next bin loads it.
    assign w_first   = (r_state != SEARCH);
    assign w_have    = !w_first && r_have;
    assign w_use     = !(SKIP_DC && (w_pbin == '0));
    // Strict compare keeps the lowest bin on ties.
    assign w_load    = w_use && (!w_have || (w_pw > r_max));
    assign w_max_nxt = w_load ? w_pw   : (w_have ? r_max     : '0);
    assign w_bin_nxt = w_load ? w_pbin : (w_have ? r_max_bin : '0);
    // tlast away from the final bin, or the final bin without tlast (wrap).
    assign w_err_hit = w_plast ? (w_pbin != LAST_BIN) : (w_pbin == LAST_BIN);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, REPORT: begin
                if (w_out_xfer)
                    w_state_nxt = w_plast ? REPORT : SEARCH;
                else if (r_state == REPORT)
                    w_state_nxt = IDLE;
            end
            SEARCH: begin
                if (w_out_xfer && w_plast)
                    w_state_nxt = REPORT;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= IDLE;
            r_max        <= '0;
            r_max_bin    <= '0;
            r_have       <= 1'b0;
            r_peak_power <= '0;
            r_peak_bin   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_out_xfer) begin
                r_max     <= w_max_nxt;
                r_max_bin <= w_bin_nxt;
                r_have    <= w_have || w_use;
                if (w_plast) begin
                    r_peak_power <= w_max_nxt;
                    r_peak_bin   <= w_bin_nxt;
                end
                if (w_first)
                    r_err <= w_err_hit;
                else if (w_err_hit)
                    r_err <= 1'b1;
            end
        end
    end

    assign peak_valid = (r_state == REPORT);
    assign peak_bin   = r_peak_bin;
    assign peak_power = r_peak_power;
    assign frame_err  = r_err;
endmodule
